jtag_dr_bank: RTL and testbench
===============================

Name: jtag_dr_bank

Overview:
- Parametrised JTAG data-register bank that sits behind the TAP controller and instruction decoder.
- Holds the boundary-scan register (BSR) with a separate update stage, plus the 32-bit IDCODE, 32-bit USERCODE and 1-bit BYPASS registers.
- Drives pin/core multiplexing for SAMPLE/PRELOAD, EXTEST, INTEST, CLAMP and HIGHZ, and presents a negedge-retimed TDO.
- Generalises the 4-pin DR block to IO_COUNT pins, adds update latches, bypass and output-enable control, and uses no gated clocks.

Parameters:
IO_COUNT, 4, number of boundary-scan pins; BSR length is 2*IO_COUNT
IDCODE, 32'h1A1000A1, IDCODE capture value; bit 0 must be 1
USERCODE, 32'h00000099, USERCODE capture value

Ports:
TCK  input  1  JTAG test clock, sole clock
TRST  input  1  asynchronous active-low reset
TDI  input  1  serial data in
CAPTUREDR  input  1  TAP Capture-DR state
SHIFTDR  input  1  TAP Shift-DR state
UPDATEDR  input  1  TAP Update-DR state
SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, BYPASS_SELECT, CLAMP_SELECT, HIGHZ_SELECT, IDCODE_SELECT, USERCODE_SELECT  input  1 each  decoded instruction
PIN_IN  input  IO_COUNT  pad input values
CORE_OUT  input  IO_COUNT  core logic values destined for pads
PIN_OUT  output  IO_COUNT  value driven to pads
PIN_OE  output  IO_COUNT  pad output enable, 1 = drive
CORE_IN  output  IO_COUNT  value presented to core logic
BSR_UPD  output  2*IO_COUNT  update-stage contents
TDO  output  1  serial data out

Behaviour:
- Interface: one clock, TCK. Reset is asynchronous and active-low: TRST.
- All registers are on posedge TCK with enables, except TDO, which is on negedge TCK.
- Reset (TRST=0) values:
  - BSR=0, BSR_UPD=0, BYPASS=0, TDO=0.
  - ID shift register = IDCODE; USER shift register = USERCODE.
- Register selection, in priority order:
  - IDCODE_SELECT > USERCODE_SELECT > INTEST > EXTEST > SAMPLE.
  - Otherwise BYPASS, which covers BYPASS, CLAMP, HIGHZ and the case where no select is active.
- BSR layout: bits [2N-1:N] are pin cells, bits [N-1:0] are core cells, with N=IO_COUNT.
- Capture (CAPTUREDR=1, posedge), for the selected register:
  - SAMPLE: BSR <= {PIN_IN, CORE_OUT}.
  - EXTEST: BSR <= {PIN_IN, BSR[N-1:0]}.
  - INTEST: BSR <= {CORE_OUT, BSR_UPD[N-1:0]}.
  - ID register <= IDCODE; USER register <= USERCODE; BYPASS <= 0.
- Shift (SHIFTDR=1, CAPTUREDR=0): the selected register shifts right, TDI enters the MSB and the LSB is the serial output. Registers that are not selected hold.
- CAPTUREDR and SHIFTDR both high: capture wins.
- Update: posedge TCK with UPDATEDR=1 and SAMPLE, EXTEST or INTEST selected: BSR_UPD <= BSR. One-cycle latency. BSR_UPD holds at all other times, including across instruction changes.
- TDO: on negedge TCK, TDO <= LSB of the selected register. It updates every negedge regardless of TAP state.
- Pin/core muxes are combinational from the selects and BSR_UPD; they follow a select change immediately:
  - PIN_OUT = (EXTEST|CLAMP) ? BSR_UPD[2N-1:N] : CORE_OUT.
  - PIN_OE = HIGHZ ? all 0 : all 1.
  - CORE_IN = INTEST ? BSR_UPD[N-1:0] : PIN_IN.
- TRST asserted mid-shift or mid-update: everything returns to reset values immediately. A partial shift is discarded and BSR_UPD is cleared.
- No width arithmetic. The BSR has no wrap; bits shifted past the LSB are lost.

Test Plan:
1. Reset, N=4, TRST=0, PIN_IN=4'hA, CORE_OUT=4'h5 -> TDO=0, BSR_UPD=8'h00, PIN_OUT=4'h5, CORE_IN=4'hA, PIN_OE=4'hF.
2. IDCODE: capture, then 32 shifts with TDI=0 -> TDO emits 32'h1A1000A1 LSB-first (first bit 1); the 33rd bit out is 0.
3. SAMPLE, N=4, PIN_IN=4'hA, CORE_OUT=4'h5:
   - Capture, then shift 8 bits of 8'h3C LSB-first -> TDO emits 1,0,1,0,0,1,0,1.
   - Update -> BSR_UPD=8'h3C.
   - Switch to EXTEST -> PIN_OUT=4'h3.
4. INTEST: preload BSR_UPD=8'h06 via SAMPLE, then select INTEST with PIN_IN=4'hF -> CORE_IN=4'h6. Capture with CORE_OUT=4'h9 -> BSR=8'h96.
5. BYPASS: capture, then shift TDI=1,0,1,1 -> TDO shows 0 (captured), then 1,0,1,1, each delayed one TCK and changing on negedge.
6. HIGHZ -> PIN_OE=4'h0 and bypass path active. TRST pulsed low mid-BSR shift -> BSR_UPD=0 and TDO=0 immediately.

Source files
------------

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: boundary-scan register with update stage, IDCODE,
// USERCODE and BYPASS, pin/core multiplexing and a negedge-retimed TDO.
module jtag_dr_bank #(
  parameter int          IO_COUNT = 4,
  parameter logic [31:0] IDCODE   = 32'h1A1000A1,
  parameter logic [31:0] USERCODE = 32'h00000099
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TDI,
  input  logic                  CAPTUREDR,
  input  logic                  SHIFTDR,
  input  logic                  UPDATEDR,
  input  logic                  SAMPLE_SELECT,
  input  logic                  EXTEST_SELECT,
  input  logic                  INTEST_SELECT,
  input  logic                  BYPASS_SELECT,
  input  logic                  CLAMP_SELECT,
  input  logic                  HIGHZ_SELECT,
  input  logic                  IDCODE_SELECT,
  input  logic                  USERCODE_SELECT,
  input  logic [IO_COUNT-1:0]   PIN_IN,
  input  logic [IO_COUNT-1:0]   CORE_OUT,
  output logic [IO_COUNT-1:0]   PIN_OUT,
  output logic [IO_COUNT-1:0]   PIN_OE,
  output logic [IO_COUNT-1:0]   CORE_IN,
  output logic [2*IO_COUNT-1:0] BSR_UPD,
  output logic                  TDO
);

  localparam int N  = IO_COUNT;
  localparam int BW = 2 * IO_COUNT;

  logic          sel_id, sel_user, sel_in, sel_ex, sel_sa, sel_bsr, sel_byp;
  logic [BW-1:0] bsr_p0;
  logic [BW-1:0] bsr_upd_p1;
  logic [31:0]   id_sr_p0;
  logic [31:0]   user_sr_p0;
  logic          byp_p0;
  logic          tdo_d;
  logic          tdo_q;

  // BYPASS is the fallback for BYPASS, CLAMP, HIGHZ and no select at all.
  always_comb begin
    sel_id   = IDCODE_SELECT;
    sel_user = !IDCODE_SELECT && USERCODE_SELECT;
    sel_in   = !IDCODE_SELECT && !USERCODE_SELECT && INTEST_SELECT;
    sel_ex   = !IDCODE_SELECT && !USERCODE_SELECT && !INTEST_SELECT && EXTEST_SELECT;
    sel_sa   = !IDCODE_SELECT && !USERCODE_SELECT && !INTEST_SELECT && !EXTEST_SELECT
               && SAMPLE_SELECT;
    sel_bsr  = sel_in || sel_ex || sel_sa;
    sel_byp  = !(sel_id || sel_user || sel_bsr);
  end

  // Stage p0: capture / shift stage of every data register
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bsr_p0 <= '0;
    end else if (CAPTUREDR && sel_bsr) begin
      if (sel_in)
        bsr_p0 <= {CORE_OUT, bsr_upd_p1[N-1:0]};
      else if (sel_ex)
        bsr_p0 <= {PIN_IN, bsr_p0[N-1:0]};
      else
        bsr_p0 <= {PIN_IN, CORE_OUT};
    end else if (SHIFTDR && sel_bsr) begin
      bsr_p0 <= {TDI, bsr_p0[BW-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      id_sr_p0   <= IDCODE;
      user_sr_p0 <= USERCODE;
      byp_p0     <= 1'b0;
    end else begin
      if (CAPTUREDR && sel_id)
        id_sr_p0 <= IDCODE;
      else if (SHIFTDR && sel_id)
        id_sr_p0 <= {TDI, id_sr_p0[31:1]};
      if (CAPTUREDR && sel_user)
        user_sr_p0 <= USERCODE;
      else if (SHIFTDR && sel_user)
        user_sr_p0 <= {TDI, user_sr_p0[31:1]};
      if (CAPTUREDR && sel_byp)
        byp_p0 <= 1'b0;
      else if (SHIFTDR && sel_byp)
        byp_p0 <= TDI;
    end
  end

  // Stage p1: update latch, held across instruction changes
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)
      bsr_upd_p1 <= '0;
    else if (UPDATEDR && sel_bsr)
      bsr_upd_p1 <= bsr_p0;
  end

  always_comb begin
    tdo_d = byp_p0;
    if (sel_id)
      tdo_d = id_sr_p0[0];
    else if (sel_user)
      tdo_d = user_sr_p0[0];
    else if (sel_bsr)
      tdo_d = bsr_p0[0];
  end

  // Falling-edge retime so TDO is stable at the tester's rising-edge sample
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST)
      tdo_q <= 1'b0;
    else
      tdo_q <= tdo_d;
  end

  assign TDO     = tdo_q;
  assign BSR_UPD = bsr_upd_p1;
  assign PIN_OUT = (EXTEST_SELECT || CLAMP_SELECT) ? bsr_upd_p1[BW-1:N] : CORE_OUT;
  assign PIN_OE  = HIGHZ_SELECT ? {N{1'b0}} : {N{1'b1}};
  assign CORE_IN = INTEST_SELECT ? bsr_upd_p1[N-1:0] : PIN_IN;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed bench for jtag_dr_bank: mux truth table plus serial scan sequences.
module tb_jtag_dr_bank;

  logic       TCK, TRST, TDI, CAPTUREDR, SHIFTDR, UPDATEDR;
  logic       SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, BYPASS_SELECT;
  logic       CLAMP_SELECT, HIGHZ_SELECT, IDCODE_SELECT, USERCODE_SELECT;
  logic [3:0] PIN_IN, CORE_OUT, PIN_OUT, PIN_OE, CORE_IN;
  logic [7:0] BSR_UPD;
  logic       TDO;

  int   checks = 0;
  int   errors = 0;
  logic tdo_mid;

  localparam logic [7:0] S_SAMPLE = 8'h80, S_EXTEST = 8'h40, S_INTEST = 8'h20,
                         S_BYPASS = 8'h10, S_CLAMP = 8'h08, S_HIGHZ = 8'h04,
                         S_ID = 8'h02, S_USER = 8'h01, S_NONE = 8'h00;

  jtag_dr_bank #(.IO_COUNT(4), .IDCODE(32'h1A1000A1), .USERCODE(32'h00000099)) dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR),
    .UPDATEDR(UPDATEDR), .SAMPLE_SELECT(SAMPLE_SELECT), .EXTEST_SELECT(EXTEST_SELECT),
    .INTEST_SELECT(INTEST_SELECT), .BYPASS_SELECT(BYPASS_SELECT),
    .CLAMP_SELECT(CLAMP_SELECT), .HIGHZ_SELECT(HIGHZ_SELECT),
    .IDCODE_SELECT(IDCODE_SELECT), .USERCODE_SELECT(USERCODE_SELECT),
    .PIN_IN(PIN_IN), .CORE_OUT(CORE_OUT), .PIN_OUT(PIN_OUT), .PIN_OE(PIN_OE),
    .CORE_IN(CORE_IN), .BSR_UPD(BSR_UPD), .TDO(TDO)
  );

  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_sel(input logic [7:0] s);
    {SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, BYPASS_SELECT,
     CLAMP_SELECT, HIGHZ_SELECT, IDCODE_SELECT, USERCODE_SELECT} = s;
  endtask

  // One TCK cycle: drive TAP controls, record TDO just after the rising edge,
  // and return 1ns after the falling edge with controls deasserted.
  task automatic step(input logic cap, input logic sh, input logic upd, input logic tdi);
    CAPTUREDR = cap;
    SHIFTDR   = sh;
    UPDATEDR  = upd;
    TDI       = tdi;
    @(posedge TCK);
    #1 tdo_mid = TDO;
    @(negedge TCK);
    #1;
    CAPTUREDR = 1'b0;
    SHIFTDR   = 1'b0;
    UPDATEDR  = 1'b0;
  endtask

  // Capture the BSR under the current select, then shift in data LSB-first,
  // checking TDO against the concatenated {data, captured} stream.
  task automatic bsr_scan(input string name, input logic [7:0] cap_val, input logic [7:0] data);
    logic [15:0] stream;
    stream = {data, cap_val};
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk($sformatf("%s_tdo0", name), 32'(TDO), 32'(stream[0]));
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b0, data[k-1]);
      chk($sformatf("%s_tdo%0d", name, k), 32'(TDO), 32'(stream[k]));
    end
  endtask

  typedef struct {
    logic [7:0] sel;
    logic [3:0] pin_in;
    logic [3:0] core_out;
    logic [3:0] exp_pout;
    logic [3:0] exp_oe;
    logic [3:0] exp_cin;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] idv;
  logic [7:0]  userv;
  logic [3:0]  byp_bits;
  logic        prev;

  initial begin
    // Muxes with BSR_UPD = 8'h3C: pin half 4'h3, core half 4'hC
    vecs[0] = '{S_SAMPLE, 4'hA, 4'h5, 4'h5, 4'hF, 4'hA};
    vecs[1] = '{S_EXTEST, 4'hA, 4'h5, 4'h3, 4'hF, 4'hA};
    vecs[2] = '{S_CLAMP,  4'hA, 4'h5, 4'h3, 4'hF, 4'hA};
    vecs[3] = '{S_HIGHZ,  4'hA, 4'h5, 4'h5, 4'h0, 4'hA};
    vecs[4] = '{S_INTEST, 4'hA, 4'h5, 4'h5, 4'hF, 4'hC};
    vecs[5] = '{S_NONE,   4'hA, 4'h5, 4'h5, 4'hF, 4'hA};
    vecs[6] = '{S_EXTEST, 4'h6, 4'h9, 4'h3, 4'hF, 4'h6};

    TRST = 1'b0; TDI = 1'b0; CAPTUREDR = 1'b0; SHIFTDR = 1'b0; UPDATEDR = 1'b0;
    set_sel(S_NONE);
    PIN_IN = 4'hA; CORE_OUT = 4'h5;
    #12;
    chk("rst_tdo", 32'(TDO), 32'd0);
    chk("rst_bsr_upd", 32'(BSR_UPD), 32'h00);
    chk("rst_pin_out", 32'(PIN_OUT), 32'h5);
    chk("rst_core_in", 32'(CORE_IN), 32'hA);
    chk("rst_pin_oe", 32'(PIN_OE), 32'hF);
    TRST = 1'b1;

    // IDCODE out LSB-first, then a zero from TDI
    idv = 32'h1A1000A1;
    set_sel(S_ID);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("id_bit0", 32'(TDO), 32'(idv[0]));
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("id_bit%0d", k), 32'(TDO), (k < 32) ? 32'(idv[k]) : 32'd0);
    end

    userv = 8'h99;
    set_sel(S_USER);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("user_bit0", 32'(TDO), 32'(userv[0]));
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("user_bit%0d", k), 32'(TDO), 32'(userv[k]));
    end

    set_sel(S_SAMPLE);
    bsr_scan("sample", 8'hA5, 8'h3C);
    chk("sample_upd_held", 32'(BSR_UPD), 32'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sample_upd", 32'(BSR_UPD), 32'h3C);

    for (int i = 0; i < 7; i++) begin
      set_sel(vecs[i].sel);
      PIN_IN   = vecs[i].pin_in;
      CORE_OUT = vecs[i].core_out;
      #1;
      chk($sformatf("mux%0d_pin_out", i), 32'(PIN_OUT), 32'(vecs[i].exp_pout));
      chk($sformatf("mux%0d_pin_oe", i), 32'(PIN_OE), 32'(vecs[i].exp_oe));
      chk($sformatf("mux%0d_core_in", i), 32'(CORE_IN), 32'(vecs[i].exp_cin));
    end
    chk("upd_held_across_sel", 32'(BSR_UPD), 32'h3C);
    @(negedge TCK);
    #1;

    // INTEST: preload 8'h06, then capture pulls CORE_OUT and the update core half
    PIN_IN = 4'hA; CORE_OUT = 4'h5;
    set_sel(S_SAMPLE);
    bsr_scan("preload", 8'hA5, 8'h06);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("preload_upd", 32'(BSR_UPD), 32'h06);
    set_sel(S_INTEST);
    PIN_IN = 4'hF;
    #1;
    chk("intest_core_in", 32'(CORE_IN), 32'h6);
    CORE_OUT = 4'h9;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("intest_cap_tdo", 32'(TDO), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("intest_cap_upd", 32'(BSR_UPD), 32'h96);

    // BYPASS: one-cycle delay, TDO moves only on the falling edge
    byp_bits = 4'b1101;
    set_sel(S_BYPASS);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("byp_cap", 32'(TDO), 32'd0);
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, byp_bits[k]);
      chk($sformatf("byp_mid%0d", k), 32'(tdo_mid), 32'(prev));
      chk($sformatf("byp_out%0d", k), 32'(TDO), 32'(byp_bits[k]));
      prev = byp_bits[k];
    end

    set_sel(S_HIGHZ);
    #1;
    chk("highz_oe", 32'(PIN_OE), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("highz_byp_cap", 32'(TDO), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("highz_byp_shift", 32'(TDO), 32'd1);

    // TRST in the middle of a BSR shift
    set_sel(S_SAMPLE);
    PIN_IN = 4'hF; CORE_OUT = 4'h9;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("pre_trst_tdo", 32'(TDO), 32'd1);
    chk("pre_trst_upd", 32'(BSR_UPD), 32'h96);
    #2 TRST = 1'b0;
    #1;
    chk("trst_upd", 32'(BSR_UPD), 32'h00);
    chk("trst_tdo", 32'(TDO), 32'd0);
    TRST = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("post_trst_tdo", 32'(TDO), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_trst_upd", 32'(BSR_UPD), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
